cla_seq_ctrl: RTL
=================

// Module: cla_seq_ctrl
// PURPOSE
//   Sequencer that time-multiplexes one 8-bit carry-lookahead slice (cla_8block) to perform
//   WIDTH-bit add/subtract over WIDTH/8 cycles, one byte per cycle, LSB byte first.
//   Sits between the ALU issue logic (valid/ready in) and writeback (valid/ready out).
//   Computes the slice's g/p vectors, chains the carry between bytes and assembles the result.
// PARAMETERS
//   WIDTH   32   operand width; multiple of 8, >= 8; NSLICE = WIDTH/8 (localparam)
// PORTS
//   clock      in   1      system clock, rising edge
//   reset_n    in   1      asynchronous, active-low reset
//   in_valid   in   1      operation request
//   in_ready   out  1      controller can accept a request
//   op_a       in   WIDTH  operand A
//   op_b       in   WIDTH  operand B
//   op_sub     in   1      1 = A - B, 0 = A + B
//   cla_a      out  8      byte of A to slice dataA
//   cla_b      out  8      byte of effective B to slice dataB
//   cla_g      out  8      cla_a & cla_b, to slice g
//   cla_p      out  8      cla_a | cla_b, to slice p
//   cla_cin    out  1      carry into the current byte
//   cla_sum    in   8      slice sum
//   cla_G      in   1      slice group generate
//   cla_P      in   1      slice group propagate
//   out_valid  out  1      result available
//   out_ready  in   1      consumer takes the result
//   result     out  WIDTH  sum/difference
//   carry_out  out  1      carry out of MSB (subtract: 1 = no borrow)
//   overflow   out  1      signed two's-complement overflow
// BEHAVIOUR
//   Reset (async, reset_n=0): state=IDLE, idx=0, carry=0, a_reg/b_reg/result=0,
//     carry_out=0, overflow=0, out_valid=0; in_ready=1 (decoded from IDLE).
//   States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. in_valid=1 at an edge: a_reg<=op_a; b_reg<=op_sub ? ~op_b : op_b;
//     carry<=op_sub; idx<=0; -> RUN. in_valid=0: stay in IDLE.
//   RUN: cla_a=a_reg[8*idx+:8], cla_b=b_reg[8*idx+:8], cla_cin=carry (combinational from regs).
//     Each edge: result[8*idx+:8]<=cla_sum; carry<=cla_G | (cla_P & carry); idx<=idx+1.
//     At idx==NSLICE-1: carry_out<=cla_G|(cla_P&carry);
//     overflow<=(a_reg[MSB]==b_reg[MSB]) && (cla_sum[7]!=a_reg[MSB]); -> DONE.
//   DONE: out_valid=1; result/carry_out/overflow held stable until out_ready=1 at an edge -> IDLE.
//   Outside RUN: cla_a/cla_b/cla_cin drive 0 (slice inputs quiet).
//   Latency: accept edge + NSLICE RUN edges; out_valid rises NSLICE cycles after accept
//     (4 for WIDTH=32). Throughput: one op per NSLICE+2 cycles minimum.
//   in_ready=0 in RUN/DONE; in_valid ignored there (no queuing, no accept in the DONE->IDLE cycle).
//   out_ready ignored outside DONE. idx wraps to 0 on entry to RUN only; never exceeds NSLICE-1.
//   result bytes not yet written in the current op keep the previous value until overwritten.
//   Reset mid-RUN/DONE aborts the op immediately; no partial result is presented.
// TESTING (bench instantiates cla_8block wired to cla_* ports, WIDTH=32)
//   add 0x000000FF+0x00000001 -> result 0x00000100, carry_out 0, overflow 0, out_valid 4 cycles after accept
//   add 0xFFFFFFFF+0x00000001 -> result 0x00000000, carry_out 1, overflow 0 (carry rippled through all 4 bytes)
//   add 0x7FFFFFFF+0x00000001 -> result 0x80000000, carry_out 0, overflow 1
//   sub 5-7 -> result 0xFFFFFFFE, carry_out 0, overflow 0; sub 0x80000000-1 -> 0x7FFFFFFF, overflow 1
//   out_ready held 0 for 3 cycles in DONE -> result stable, in_ready 0, in_valid pulses ignored; then IDLE
//   reset_n low after 2 RUN cycles -> all outputs at reset values at once; next add 3+4 -> 0x00000007

Source files
------------

// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: drives one 8-bit CLA slice over WIDTH/8 cycles to form a WIDTH-bit add/subtract
module cla_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic [7:0]       cla_a,
  output logic [7:0]       cla_b,
  output logic [7:0]       cla_g,
  output logic [7:0]       cla_p,
  output logic             cla_cin,
  input  logic [7:0]       cla_sum,
  input  logic             cla_G,
  input  logic             cla_P,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);
  localparam int NSLICE = WIDTH / 8;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, nxt;
  logic [IW-1:0]     idx;
  logic              carry;
  logic [WIDTH-1:0]  a_reg, b_reg;
  logic              last, cnext;

  assign last      = idx == IW'(NSLICE - 1);
  assign cnext     = cla_G | (cla_P & carry);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign cla_a     = state == RUN ? a_reg[8*idx +: 8] : 8'd0;
  assign cla_b     = state == RUN ? b_reg[8*idx +: 8] : 8'd0;
  assign cla_cin   = state == RUN ? carry : 1'b0;
  assign cla_g     = cla_a & cla_b;
  assign cla_p     = cla_a | cla_b;

  // state register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= nxt;

  // next-state: accept in IDLE, step bytes in RUN, hold result until taken in DONE
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = in_valid ? RUN : IDLE;
      RUN:     nxt = last ? DONE : RUN;
      DONE:    nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end

  // operand capture, per-byte result assembly and carry chaining between bytes
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      idx       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_reg <= op_a;
      b_reg <= op_sub ? ~op_b : op_b;
      carry <= op_sub;
      idx   <= '0;
    end else if (state == RUN) begin
      result[8*idx +: 8] <= cla_sum;
      carry              <= cnext;
      idx                <= last ? '0 : idx + 1'b1;
      if (last) begin
        carry_out <= cnext;
        overflow  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (cla_sum[7] != a_reg[WIDTH-1]);
      end
    end
endmodule
